// File: rtl/aq_lsu_bus_arb.sv
// rtl/aq_lsu_bus_arb.sv - locked multi-beat arbiter sharing one LSU bus request channel
//
// Ports:
//   clk, rst_b            clock; asynchronous active-low reset
//   req_vld/last/data     per-requester beat stream (requester i uses req_data[i*DW +: DW])
//   req_rdy               per-requester beat accepted (only the owner can see out_rdy)
//   out_vld/last/data     downstream beat stream, forwarded combinationally from the owner
//   out_id                binary index of the current owner, held while idle
//   out_rdy               downstream ready
//   arb_busy              channel locked to an owner
//   arb_gnt               one-hot owner, zero while idle
module aq_lsu_bus_arb #(
  parameter int NUM = 4,
  parameter int DW  = 64,
  parameter int IDW = 2
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [NUM-1:0]    req_vld,
  input  logic [NUM-1:0]    req_last,
  input  logic [NUM*DW-1:0] req_data,
  output logic [NUM-1:0]    req_rdy,
  output logic              out_vld,
  output logic              out_last,
  output logic [DW-1:0]     out_data,
  output logic [IDW-1:0]    out_id,
  input  logic              out_rdy,
  output logic              arb_busy,
  output logic [NUM-1:0]    arb_gnt
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e                     state_q, state_d;
  logic [NUM-1:0]             gnt_q, gnt_d;
  logic [IDW-1:0]             id_q, id_d;
  // older_q[i][j] set means requester i outranks requester j; diagonal unused.
  logic [NUM-1:0][NUM-1:0]    older_q, older_d;

  logic [NUM-1:0]             win;
  logic                       sel_vld;
  logic                       sel_last;
  logic [DW-1:0]              sel_data;
  logic                       xfer_last;

  // Reset ranking: lower index outranks higher index.
  function automatic logic [NUM-1:0][NUM-1:0] reset_order();
    logic [NUM-1:0][NUM-1:0] r;
    r = '0;
    for (int i = 0; i < NUM; i++) begin
      for (int j = 0; j < NUM; j++) begin
        r[i][j] = (i < j);
      end
    end
    return r;
  endfunction

  // A valid requester wins when no other valid requester outranks it.
  // The matrix always holds a total order, so at most one bit survives.
  always_comb begin
    win = '0;
    for (int i = 0; i < NUM; i++) begin
      win[i] = req_vld[i];
      for (int j = 0; j < NUM; j++) begin
        if (j != i && req_vld[j] && older_q[j][i]) begin
          win[i] = 1'b0;
        end
      end
    end
  end

  // Owner mux: gnt_q is one-hot in BUSY and zero in IDLE, so an AND-OR select suffices.
  always_comb begin
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NUM; i++) begin
      if (gnt_q[i]) begin
        sel_vld  = sel_vld  | req_vld[i];
        sel_last = sel_last | req_last[i];
        sel_data = sel_data | req_data[i*DW +: DW];
      end
    end
  end

  assign arb_busy  = (state_q == BUSY);
  assign arb_gnt   = gnt_q;
  assign out_id    = id_q;
  assign out_vld   = arb_busy & sel_vld;
  assign out_last  = arb_busy & sel_last;
  assign out_data  = sel_data;
  assign req_rdy   = arb_busy ? (gnt_q & {NUM{out_rdy}}) : '0;
  assign xfer_last = out_vld & out_rdy & out_last;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    older_d = older_q;
    case (state_q)
      IDLE: begin
        if (|req_vld) begin
          state_d = BUSY;
          gnt_d   = win;
          for (int i = 0; i < NUM; i++) begin
            if (win[i]) begin
              id_d = IDW'(i);
            end
          end
        end
      end
      BUSY: begin
        if (xfer_last) begin
          state_d = IDLE;
          gnt_d   = '0;
          // Demote the finishing owner below everyone; other pairs keep their order.
          for (int i = 0; i < NUM; i++) begin
            if (gnt_q[i]) begin
              for (int j = 0; j < NUM; j++) begin
                if (j != i) begin
                  older_d[i][j] = 1'b0;
                  older_d[j][i] = 1'b1;
                end
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      older_q <= reset_order();
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      older_q <= older_d;
    end
  end

endmodule

// File: tb/tb_aq_lsu_bus_arb.sv
// tb/tb_aq_lsu_bus_arb.sv - scoreboard bench for aq_lsu_bus_arb
module tb_aq_lsu_bus_arb;
  localparam int NUM = 4;
  localparam int DW  = 64;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              rst_b;
  logic [NUM-1:0]    req_vld;
  logic [NUM-1:0]    req_last;
  logic [NUM*DW-1:0] req_data;
  logic [NUM-1:0]    req_rdy;
  logic              out_vld;
  logic              out_last;
  logic [DW-1:0]     out_data;
  logic [IDW-1:0]    out_id;
  logic              out_rdy;
  logic              arb_busy;
  logic [NUM-1:0]    arb_gnt;

  aq_lsu_bus_arb #(.NUM(NUM), .DW(DW), .IDW(IDW)) dut (
    .clk(clk), .rst_b(rst_b),
    .req_vld(req_vld), .req_last(req_last), .req_data(req_data), .req_rdy(req_rdy),
    .out_vld(out_vld), .out_last(out_last), .out_data(out_data), .out_id(out_id),
    .out_rdy(out_rdy), .arb_busy(arb_busy), .arb_gnt(arb_gnt)
  );

  always #5 clk = ~clk;

  typedef struct {logic [DW-1:0] data; logic last;} beat_t;
  typedef struct {logic [IDW-1:0] id; logic [DW-1:0] data; logic last;} exp_t;
  typedef struct {int cyc; logic [NUM-1:0] g;} glog_t;

  beat_t          srcq[NUM][$];
  exp_t           exp_q[$];
  glog_t          glog[$];
  logic [NUM-1:0] hold;
  logic [NUM-1:0] acc;
  logic [NUM-1:0] prev_g;
  int             n_chk  = 0;
  int             n_fail = 0;
  int             cyc    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int id, input int n);
    return 64'hBEEF_0000_0000_0000 | (64'(id) << 16) | 64'(n);
  endfunction

  // Queue a burst at the source and its expected downstream beats in grant order.
  task automatic send(input int id, input int nbeats, input int tag);
    for (int b = 0; b < nbeats; b++) begin
      srcq[id].push_back(beat_t'{mk(id, tag + b), (b == nbeats - 1)});
      exp_q.push_back(exp_t'{IDW'(id), mk(id, tag + b), (b == nbeats - 1)});
    end
  endtask

  function automatic bit srcs_empty();
    for (int i = 0; i < NUM; i++) begin
      if (srcq[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Source driver: pops beats accepted at the previous edge, presents the next head.
  initial begin
    req_vld  = '0;
    req_last = '0;
    req_data = '0;
    forever begin
      @(negedge clk);
      acc = req_vld & req_rdy;
      @(posedge clk);
      #2;
      for (int i = 0; i < NUM; i++) begin
        if (acc[i] && srcq[i].size() > 0) srcq[i].delete(0);
        if (srcq[i].size() > 0 && !hold[i]) begin
          req_vld[i]              = 1'b1;
          req_last[i]             = srcq[i][0].last;
          req_data[i*DW +: DW]    = srcq[i][0].data;
        end else begin
          req_vld[i]  = 1'b0;
          req_last[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: scoreboard pop on every downstream transfer, grant logging.
  initial begin
    exp_t e;
    prev_g = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_b) begin
        chk("gnt_onehot", 64'($onehot0(arb_gnt)), 64'd1);
        if (arb_gnt !== prev_g && arb_gnt != '0) glog.push_back(glog_t'{cyc, arb_gnt});
        prev_g = arb_gnt;
        if (out_vld && out_rdy) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_beat: got id %0d data %0h, expected no beat", out_id, out_data);
          end else begin
            e = exp_q.pop_front();
            chk("beat_id", 64'(out_id), 64'(e.id));
            chk("beat_data", out_data, e.data);
            chk("beat_last", 64'(out_last), 64'(e.last));
          end
        end
      end else begin
        prev_g = '0;
      end
    end
  end

  task automatic wait_gnt(input logic [NUM-1:0] g, input string name);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (arb_gnt !== g && k < 50);
    chk(name, 64'(arb_gnt), 64'(g));
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    bit done;
    do begin
      @(negedge clk);
      k++;
      done = (exp_q.size() == 0) && !arb_busy && srcs_empty();
    end while (!done && k < 200);
    chk(name, 64'(done), 64'd1);
  endtask

  // ids: nibble k holds the expected owner of grant k; gap: expected cycles between grants.
  task automatic chk_order(input string name, input int n, input logic [31:0] ids, input int gap);
    chk({name, "_ngrants"}, 64'(glog.size()), 64'(n));
    for (int k = 0; k < n && k < glog.size(); k++) begin
      chk({name, "_gnt"}, 64'(glog[k].g), 64'(4'b0001 << ids[k*4 +: 4]));
      if (k > 0 && gap > 0) chk({name, "_gap"}, 64'(glog[k].cyc - glog[k-1].cyc), 64'(gap));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_b   = 1'b1;
    out_rdy = 1'b0;
    hold    = '0;
    #1 rst_b = 1'b0;
    #1;
    chk("rst_gnt", 64'(arb_gnt), 64'd0);
    chk("rst_busy", 64'(arb_busy), 64'd0);
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_req_rdy", 64'(req_rdy), 64'd0);
    chk("rst_out_id", 64'(out_id), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b1;

    // Round robin over four single-beat requesters.
    @(posedge clk); #1;
    out_rdy = 1'b1;
    glog.delete();
    send(0, 1, 0); send(1, 1, 0); send(2, 1, 0); send(3, 1, 0); send(0, 1, 1);
    wait_drain("t1_drain");
    chk_order("t1", 5, 32'h0000_3210, 2);

    // Req 0 arrives mid-burst of req 2 and waits for the burst plus one idle cycle.
    @(posedge clk); #1;
    glog.delete();
    send(2, 3, 16);
    wait_gnt(4'b0100, "t2_gnt2");
    @(posedge clk); #1;
    send(0, 1, 32);
    wait_drain("t2_drain");
    chk_order("t2", 2, 32'h0000_0002, 4);

    // Downstream stall: payload held, owner not accepted, channel stays locked.
    @(posedge clk); #1;
    glog.delete();
    out_rdy = 1'b0;
    send(3, 2, 48);
    wait_gnt(4'b1000, "t3_gnt3");
    for (int s = 0; s < 5; s++) begin
      if (s > 0) @(negedge clk);
      chk("t3_stall_data", out_data, mk(3, 48));
      chk("t3_stall_vld", 64'(out_vld), 64'd1);
      chk("t3_stall_rdy", 64'(req_rdy), 64'd0);
      chk("t3_stall_busy", 64'(arb_busy), 64'd1);
    end
    @(posedge clk); #1;
    out_rdy = 1'b1;
    wait_drain("t3_drain");
    chk_order("t3", 1, 32'h0000_0003, 0);

    // Owner gap between beats: no valid downstream, grant held.
    @(posedge clk); #1;
    glog.delete();
    send(1, 3, 64);
    wait_gnt(4'b0010, "t4_gnt1");
    @(posedge clk); #1;
    hold[1] = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("t4_gap_vld", 64'(out_vld), 64'd0);
      chk("t4_gap_gnt", 64'(arb_gnt), 64'(4'b0010));
      chk("t4_gap_busy", 64'(arb_busy), 64'd1);
    end
    @(posedge clk); #1;
    hold[1] = 1'b0;
    wait_drain("t4_drain");
    chk_order("t4", 1, 32'h0000_0001, 0);

    // After req 1 finished, 4'b0011 favours req 0, then req 1, then req 0 again.
    @(posedge clk); #1;
    glog.delete();
    send(0, 1, 80); send(1, 1, 80); send(0, 1, 81);
    wait_drain("t5_drain");
    chk_order("t5", 3, 32'h0000_0010, 2);

    // Asynchronous reset during beat 2 of a 4-beat burst.
    @(posedge clk); #1;
    send(2, 4, 96);
    wait_gnt(4'b0100, "t6_gnt2");
    @(posedge clk); #3;
    rst_b = 1'b0;
    srcq[2].delete();
    #1;
    chk("t6_rst_gnt", 64'(arb_gnt), 64'd0);
    chk("t6_rst_vld", 64'(out_vld), 64'd0);
    chk("t6_rst_rdy", 64'(req_rdy), 64'd0);
    chk("t6_rst_busy", 64'(arb_busy), 64'd0);
    chk("t6_rst_id", 64'(out_id), 64'd0);
    chk("t6_beats_left", 64'(exp_q.size()), 64'd3);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;
    @(posedge clk); #1;
    glog.delete();
    send(1, 1, 112); send(3, 1, 112);
    wait_drain("t6_drain");
    chk_order("t6", 2, 32'h0000_0031, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
